// File: rtl/dcache_dm.sv
// rtl/dcache_dm.sv - direct-mapped write-through read-allocate data cache
//
// Purpose: one 32-bit word per line, 2^INDEX_W lines. Read hits return data
// with single-cycle latency and no stall. Every write goes through to memory.
// Read misses refill the whole word from memory. There is no write-allocate.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   ram_raddr_i         read word address from master
//   ram_waddr_i         write word address from master
//   ram_data_i          write data from master
//   ram_we_i, ram_re_i  write / read request
//   ram_sel_i           write byte enables
//   ram_data_o          registered read data to master
//   stall_o             master holds its request while high
//   mem_req_o           memory request (registered)
//   mem_we_o            memory write (1) / read (0)
//   mem_addr_o          memory word address
//   mem_wdata_o         memory write data
//   mem_sel_o           memory byte enables
//   mem_rdata_i         memory read data, valid with ack
//   mem_ack_i           memory completion pulse
//   hit_cnt_o           read-hit counter
//   miss_cnt_o          read-miss counter
module dcache_dm #(
   parameter int INDEX_W = 4,
   parameter int ADDR_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] ram_raddr_i,
   input  logic [ADDR_W-1:0] ram_waddr_i,
   input  logic [31:0]       ram_data_i,
   input  logic              ram_we_i,
   input  logic              ram_re_i,
   input  logic [3:0]        ram_sel_i,
   output logic [31:0]       ram_data_o,
   output logic              stall_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   output logic [3:0]        mem_sel_o,
   input  logic [31:0]       mem_rdata_i,
   input  logic              mem_ack_i,
   output logic [31:0]       hit_cnt_o,
   output logic [31:0]       miss_cnt_o
);

   localparam int LINES = 1 << INDEX_W;
   localparam int TAG_W = ADDR_W - INDEX_W;

   typedef enum logic [1:0] {IDLE, WR_MEM, RD_MEM} state_t;
   state_t state, state_nxt;

   logic [LINES-1:0] valid;
   logic [TAG_W-1:0] tag_arr  [LINES];
   logic [31:0]      data_arr [LINES];

   // The master keeps its request asserted through the stall, so the first
   // IDLE cycle after a memory transaction sees the same request again. These
   // flags mark that cycle so the finished part is not issued a second time.
   logic wr_done;
   logic rd_done;

   logic [INDEX_W-1:0] r_idx, w_idx, f_idx;
   logic [TAG_W-1:0]   r_tag, w_tag, f_tag;
   logic               rd_hit, wr_hit, mem_done;
   logic               acc_wr, acc_rd_hit, acc_rd_miss;

   assign r_idx = ram_raddr_i[INDEX_W-1:0];
   assign r_tag = ram_raddr_i[ADDR_W-1:INDEX_W];
   assign w_idx = ram_waddr_i[INDEX_W-1:0];
   assign w_tag = ram_waddr_i[ADDR_W-1:INDEX_W];
   // Refill target comes from the latched miss address, not the live inputs.
   assign f_idx = mem_addr_o[INDEX_W-1:0];
   assign f_tag = mem_addr_o[ADDR_W-1:INDEX_W];

   assign rd_hit   = valid[r_idx] && (tag_arr[r_idx] == r_tag);
   assign wr_hit   = valid[w_idx] && (tag_arr[w_idx] == w_tag);
   assign mem_done = mem_req_o && mem_ack_i;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      stall_o     = 1'b0;
      acc_wr      = 1'b0;
      acc_rd_hit  = 1'b0;
      acc_rd_miss = 1'b0;
      unique case (state)
         IDLE: begin
            // Post-refill cycle: the read was already answered on the ack edge.
            if (!rd_done) begin
               if (ram_we_i && !wr_done) begin
                  acc_wr    = 1'b1;
                  stall_o   = 1'b1;
                  state_nxt = WR_MEM;
               end else if (ram_re_i) begin
                  if (rd_hit) begin
                     acc_rd_hit = 1'b1;
                  end else begin
                     acc_rd_miss = 1'b1;
                     stall_o     = 1'b1;
                     state_nxt   = RD_MEM;
                  end
               end
            end
         end
         WR_MEM: begin
            stall_o = 1'b1;
            if (mem_done) state_nxt = IDLE;
         end
         RD_MEM: begin
            stall_o = 1'b1;
            if (mem_done) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid       <= '0;
         ram_data_o  <= '0;
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         mem_sel_o   <= '0;
         hit_cnt_o   <= '0;
         miss_cnt_o  <= '0;
         wr_done     <= 1'b0;
         rd_done     <= 1'b0;
      end else begin
         wr_done <= 1'b0;
         rd_done <= 1'b0;
         if (acc_wr) begin
            mem_req_o   <= 1'b1;
            mem_we_o    <= 1'b1;
            mem_addr_o  <= ram_waddr_i;
            mem_wdata_o <= ram_data_i;
            mem_sel_o   <= ram_sel_i;
         end
         if (acc_rd_hit) begin
            ram_data_o <= data_arr[r_idx];
            hit_cnt_o  <= hit_cnt_o + 32'd1;
         end
         if (acc_rd_miss) begin
            miss_cnt_o <= miss_cnt_o + 32'd1;
            mem_req_o  <= 1'b1;
            mem_we_o   <= 1'b0;
            mem_addr_o <= ram_raddr_i;
            mem_sel_o  <= 4'b1111;
         end
         if (state != IDLE && mem_done) begin
            mem_req_o <= 1'b0;
            if (state == RD_MEM) begin
               valid[f_idx] <= 1'b1;
               ram_data_o   <= mem_rdata_i;
               rd_done      <= 1'b1;
            end else begin
               wr_done <= 1'b1;
            end
         end
      end
   end

   // Tag/data storage needs no reset; the valid bits qualify it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (acc_wr && wr_hit) begin
            for (int b = 0; b < 4; b++) begin
               if (ram_sel_i[b]) data_arr[w_idx][8*b +: 8] <= ram_data_i[8*b +: 8];
            end
         end
         if (state == RD_MEM && mem_done) begin
            tag_arr[f_idx]  <= f_tag;
            data_arr[f_idx] <= mem_rdata_i;
         end
      end
   end

endmodule

// File: tb/tb_dcache_dm.sv
// tb/tb_dcache_dm.sv - directed scoreboard bench for dcache_dm
`timescale 1ns/1ps
module tb_dcache_dm;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ram_raddr, ram_waddr, ram_wdata;
   logic        ram_we, ram_re;
   logic [3:0]  ram_sel;
   logic [31:0] ram_data_o;
   logic        stall_o;
   logic        mem_req_o, mem_we_o;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic [3:0]  mem_sel_o;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic [31:0] hit_cnt_o, miss_cnt_o;

   always #5 clk = ~clk;

   dcache_dm #(.INDEX_W(4), .ADDR_W(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .ram_raddr_i (ram_raddr),
      .ram_waddr_i (ram_waddr),
      .ram_data_i  (ram_wdata),
      .ram_we_i    (ram_we),
      .ram_re_i    (ram_re),
      .ram_sel_i   (ram_sel),
      .ram_data_o  (ram_data_o),
      .stall_o     (stall_o),
      .mem_req_o   (mem_req_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_sel_o   (mem_sel_o),
      .mem_rdata_i (mem_rdata),
      .mem_ack_i   (mem_ack),
      .hit_cnt_o   (hit_cnt_o),
      .miss_cnt_o  (miss_cnt_o)
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  sel;
      logic [31:0] wdata;
   } mem_txn_t;

   mem_txn_t    exp_mem_q[$];
   logic [31:0] exp_rd_q[$];
   logic [31:0] mem_store [256];

   int checks = 0;
   int errors = 0;
   int mem_lat = 0;
   bit mem_auto = 1'b1;
   int wait_cnt = 0;
   int exp_hits = 0;
   int exp_misses = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Memory model: acks after mem_lat waiting cycles and checks each
   // transaction against the expected-transaction queue.
   always @(negedge clk) begin : mem_model
      mem_txn_t e;
      if (mem_auto) begin
         if (mem_ack) begin
            mem_ack = 1'b0;
         end else if (mem_req_o) begin
            if (wait_cnt >= mem_lat) begin
               wait_cnt = 0;
               check("mem_txn_expected", 32'(exp_mem_q.size() != 0), 32'd1);
               if (exp_mem_q.size() != 0) begin
                  e = exp_mem_q.pop_front();
                  check("mem_we", 32'(mem_we_o), 32'(e.we));
                  check("mem_addr", mem_addr_o, e.addr);
                  check("mem_sel", 32'(mem_sel_o), 32'(e.sel));
                  if (e.we) check("mem_wdata", mem_wdata_o, e.wdata);
               end
               if (mem_we_o) begin
                  for (int b = 0; b < 4; b++)
                     if (mem_sel_o[b]) mem_store[mem_addr_o[7:0]][8*b +: 8] = mem_wdata_o[8*b +: 8];
               end else begin
                  mem_rdata = mem_store[mem_addr_o[7:0]];
               end
               mem_ack = 1'b1;
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   // Called and returns on a negedge.
   task automatic do_req(input bit we, input bit re, input logic [31:0] waddr,
                         input logic [31:0] raddr, input logic [31:0] wdata,
                         input logic [3:0] sel, input bit exp_hit,
                         input logic [31:0] exp_rdata, input int exp_stall,
                         input string tag);
      int n = 0;
      mem_txn_t t;
      if (we) begin
         t.we = 1'b1; t.addr = waddr; t.sel = sel; t.wdata = wdata;
         exp_mem_q.push_back(t);
      end
      if (re) begin
         exp_rd_q.push_back(exp_rdata);
         if (exp_hit) begin
            exp_hits++;
         end else begin
            exp_misses++;
            t.we = 1'b0; t.addr = raddr; t.sel = 4'hF; t.wdata = 32'h0;
            exp_mem_q.push_back(t);
         end
      end
      ram_we = we; ram_re = re; ram_waddr = waddr; ram_raddr = raddr;
      ram_wdata = wdata; ram_sel = sel;
      #1;
      while (stall_o && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      check({tag, "_stall_release"}, 32'(stall_o), 32'd0);
      if (exp_stall >= 0) check({tag, "_stall_cycles"}, n, exp_stall);
      @(negedge clk);
      ram_we = 1'b0;
      ram_re = 1'b0;
      if (re && exp_rd_q.size() != 0) check({tag, "_rdata"}, ram_data_o, exp_rd_q.pop_front());
      check({tag, "_hit_cnt"}, hit_cnt_o, exp_hits);
      check({tag, "_miss_cnt"}, miss_cnt_o, exp_misses);
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1; ram_we = 1'b0; ram_re = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      exp_hits = 0;
      exp_misses = 0;
      check({tag, "_ram_data"}, ram_data_o, 32'h0);
      check({tag, "_stall"}, 32'(stall_o), 32'd0);
      check({tag, "_mem_req"}, 32'(mem_req_o), 32'd0);
      check({tag, "_mem_we"}, 32'(mem_we_o), 32'd0);
      check({tag, "_mem_addr"}, mem_addr_o, 32'h0);
      check({tag, "_mem_wdata"}, mem_wdata_o, 32'h0);
      check({tag, "_mem_sel"}, 32'(mem_sel_o), 32'd0);
      check({tag, "_hit_cnt"}, hit_cnt_o, 32'd0);
      check({tag, "_miss_cnt"}, miss_cnt_o, 32'd0);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors + 1);
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      logic [31:0] d;
      rst = 1'b1; ram_we = 1'b0; ram_re = 1'b0; ram_sel = 4'h0;
      ram_raddr = '0; ram_waddr = '0; ram_wdata = '0;
      mem_ack = 1'b0; mem_rdata = '0;
      for (int i = 0; i < 256; i++) mem_store[i] = 32'hDEAD_0000 | i;

      // Reset values, then a miss with 2-cycle memory latency followed by a hit.
      do_reset("rst0");
      mem_store[3] = 32'h0000_1234;
      mem_lat = 2;
      do_req(0, 1, 0, 32'h3, 0, 4'h0, 0, 32'h0000_1234, 4, "rd3_miss");
      do_req(0, 1, 0, 32'h3, 0, 4'h0, 1, 32'h0000_1234, 0, "rd3_hit");

      // Write-through of 16 words, each read back via a miss, then 16 hits.
      do_reset("rst1");
      mem_lat = 0;
      for (int i = 0; i < 16; i++) begin
         d = {i[7:0], 8'h5A, ~i[7:0], 8'hC3};
         do_req(1, 0, i, 0, d, 4'hF, 0, 0, 2, "loop_wr");
         do_req(0, 1, 0, i, 0, 4'h0, 0, d, 2, "loop_rd_miss");
      end
      for (int i = 0; i < 16; i++) begin
         d = {i[7:0], 8'h5A, ~i[7:0], 8'hC3};
         do_req(0, 1, 0, i, 0, 4'h0, 1, d, 0, "loop_rd_hit");
      end

      // Partial write hit merges one byte.
      do_reset("rst2");
      mem_lat = 1;
      mem_store[5] = 32'hAABB_CCDD;
      do_req(0, 1, 0, 32'h5, 0, 4'h0, 0, 32'hAABB_CCDD, 3, "fill5");
      do_req(1, 0, 32'h5, 0, 32'h0000_0011, 4'b0001, 0, 0, 3, "wr5_byte");
      do_req(0, 1, 0, 32'h5, 0, 4'h0, 1, 32'hAABB_CC11, 0, "rd5_merged");
      check("mem5_merged", mem_store[5], 32'hAABB_CC11);

      // Index aliasing: 0x02 and 0x12 share line 2.
      mem_lat = 0;
      mem_store[8'h02] = 32'h0202_0202;
      mem_store[8'h12] = 32'h1212_1212;
      do_req(0, 1, 0, 32'h02, 0, 4'h0, 0, 32'h0202_0202, 2, "alias_a");
      do_req(0, 1, 0, 32'h12, 0, 4'h0, 0, 32'h1212_1212, 2, "alias_b");
      do_req(0, 1, 0, 32'h02, 0, 4'h0, 0, 32'h0202_0202, 2, "alias_a2");

      // Simultaneous write+read to a valid line: write first, read sees new data.
      mem_store[7] = 32'h0000_0077;
      do_req(0, 1, 0, 32'h7, 0, 4'h0, 0, 32'h0000_0077, 2, "fill7");
      do_req(1, 1, 32'h7, 32'h7, 32'h0000_CAFE, 4'hF, 1, 32'h0000_CAFE, 2, "wr_rd7");
      check("mem7_written", mem_store[7], 32'h0000_CAFE);
      check("mem_q_drained_mid", exp_mem_q.size(), 0);

      // Reset in the middle of a refill; the late ack must be ignored.
      mem_auto = 1'b0;
      ram_raddr = 32'h9; ram_re = 1'b1;
      #1;
      check("rst_mid_stall", 32'(stall_o), 32'd1);
      @(negedge clk);
      check("rst_mid_req", 32'(mem_req_o), 32'd1);
      rst = 1'b1; ram_re = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      exp_hits = 0; exp_misses = 0;
      check("rst_mid_req_low", 32'(mem_req_o), 32'd0);
      mem_rdata = 32'h5555_5555;
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      check("late_ack_req", 32'(mem_req_o), 32'd0);
      check("late_ack_stall", 32'(stall_o), 32'd0);
      check("late_ack_data", ram_data_o, 32'h0);
      check("late_ack_miss", miss_cnt_o, 32'd0);
      wait_cnt = 0;
      mem_auto = 1'b1;
      mem_store[9] = 32'h0909_0909;
      do_req(0, 1, 0, 32'h9, 0, 4'h0, 0, 32'h0909_0909, 2, "rd9_after_rst");

      check("mem_q_drained", exp_mem_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dcache_dm.md
# dcache_dm

Direct-mapped, write-through, read-allocate data cache that sits directly downstream of the CPU/test driver's `ram_*` data port and upstream of the data memory model. It serves read hits from a tag/data array with single-cycle latency. It forwards every write to memory and stalls the master on read misses and writes. It exposes hit/miss counters so directed benches can check cache behaviour as well as data integrity.

## Interface
Parameters:
- `INDEX_W`, default 4: line-index width; number of lines is 2^INDEX_W, one 32-bit word per line.
- `ADDR_W`, default 32: word-address width; tag = addr[ADDR_W-1:INDEX_W].

Ports:
- `clk` in 1: single clock, all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `ram_raddr_i` in ADDR_W: read word address from master.
- `ram_waddr_i` in ADDR_W: write word address from master.
- `ram_data_i` in 32: write data from master.
- `ram_we_i` in 1: write request.
- `ram_re_i` in 1: read request.
- `ram_sel_i` in 4: byte enables; bit n covers data[8n+7:8n].
- `ram_data_o` out 32: registered read data to master.
- `stall_o` out 1: master must hold all request inputs stable while high.
- `mem_req_o` out 1: memory request.
- `mem_we_o` out 1: 1 = memory write, 0 = memory read.
- `mem_addr_o` out ADDR_W: memory word address.
- `mem_wdata_o` out 32: memory write data.
- `mem_sel_o` out 4: memory byte enables.
- `mem_rdata_i` in 32: memory read data, valid with ack.
- `mem_ack_i` in 1: memory completion, one-cycle pulse.
- `hit_cnt_o` out 32: count of read hits.
- `miss_cnt_o` out 32: count of read misses.

## Operation
- States: IDLE, WR_MEM, RD_MEM.
- IDLE, `ram_we_i`=1:
  - On a write hit (valid and tag match at the write index), merge bytes into the line per `ram_sel_i`.
  - On a write miss, leave the array unchanged (no write-allocate).
  - Latch address, data and sel into the memory port, then go to WR_MEM.
- IDLE, `ram_re_i`=1 and `ram_we_i`=0:
  - Read hit: `ram_data_o` <= line data, `hit_cnt_o`+1, stay in IDLE.
  - Read miss: `miss_cnt_o`+1, latch read address, go to RD_MEM with `mem_sel_o`=4'b1111.
- Simultaneous `ram_we_i` and `ram_re_i`: the write is processed first. After it returns to IDLE with the inputs still held, the read is looked up against the updated array, so a read of the just-written address returns the new data.
- WR_MEM: wait for `mem_ack_i`, then return to IDLE.
- RD_MEM: on `mem_ack_i`:
  - the line at the index gets valid=1, tag and `mem_rdata_i`;
  - `ram_data_o` <= `mem_rdata_i`;
  - return to IDLE.
- Read misses always fetch the full word; `ram_sel_i` does not mask read data.
- Counters wrap modulo 2^32. Only read lookups in IDLE are counted: one per accepted read, never counted again on the post-refill cycle.
- Reset:
  - all valid bits are cleared, FSM goes to IDLE;
  - `ram_data_o`, `mem_addr_o`, `mem_wdata_o`, `hit_cnt_o` and `miss_cnt_o` go to 0;
  - `mem_sel_o` = 0;
  - `mem_req_o`, `mem_we_o` and `stall_o` go to 0.
- Reset mid-transaction abandons it. A `mem_ack_i` arriving after reset while IDLE is ignored.

## Timing
- `stall_o` is combinational: high when state != IDLE, or in IDLE when a write is requested, or a read misses. It is low on the read-hit cycle.
- Read hit: request sampled at edge N, `ram_data_o` valid after edge N, zero stall cycles.
- `mem_req_o`, `mem_we_o`, `mem_addr_o`, `mem_wdata_o` and `mem_sel_o` are registered:
  - `mem_req_o` rises on the edge entering WR_MEM/RD_MEM;
  - it is held with stable address, data and sel until `mem_ack_i` is sampled high;
  - it falls on that same edge.
- `mem_ack_i` is only honoured while `mem_req_o`=1. It may arrive in the first cycle that req is high, which gives minimum latency.
- Write: stall spans the accept cycle plus WR_MEM cycles. With ack in the first req cycle that is 2 cycles. Back-to-back requests are accepted on the first IDLE cycle after.
- Read miss: `ram_data_o` is valid on the edge of ack. `stall_o` falls in the following IDLE cycle, and no re-lookup is counted.
- Index aliasing: a read miss to an index holding another tag overwrites that line. There are no dirty lines, so no writeback is needed.

## Test plan
- Reset, then read addr 0x3 with memory returning 0x1234 after 2 cycles -> `miss_cnt_o`=1, `ram_data_o`=0x1234; a second read of 0x3 -> hit, zero stall, `hit_cnt_o`=1.
- For i=0..15, write data[i] to addr i (sel 1111), then read addr i -> every read returns data[i]. Memory sees 16 writes, 16 read misses. A repeat pass gives 16 hits.
- After line 0x5 is filled with 0xAABBCCDD, write 0x00000011 with sel 0001 -> a read hit returns 0xAABBCC11, and memory receives sel 0001.
- Read 0x02 then 0x12 (same index, INDEX_W=4), then 0x02 again -> three misses; memory sees addresses 0x02, 0x12, 0x02.
- Same-cycle we+re to addr 0x7 with data 0xCAFE (line 0x7 already valid) -> memory write completes first; `ram_data_o`=0xCAFE; hit counted.
- Assert rst while in RD_MEM, then deliver ack -> `mem_req_o` low, line not filled; a subsequent read of that address misses.
